// File: rtl/flash_array_ctrl.sv
// Sequencer for a NAND-string flash array macro.
// Handles READ / PROGRAM (with verify and per-bit inhibit) / ERASE.
module flash_array_ctrl #(
    parameter int NUM_BL     = 8,
    parameter int NUM_STR    = 2,
    parameter int WL_PER_STR = 4,
    parameter int T_SETUP    = 2,
    parameter int T_PRECH    = 4,
    parameter int T_SENSE    = 3,
    parameter int T_PGM      = 8,
    parameter int T_ERS      = 16,
    parameter int MAX_PULSES = 4,
    localparam int NROW      = NUM_STR * WL_PER_STR,
    localparam int ROW_W     = $clog2(NROW),
    localparam int WLB       = $clog2(WL_PER_STR)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [NUM_BL-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NUM_BL-1:0] rsp_data,
    output logic              rsp_fail,
    output logic              busy,
    output logic [NUM_STR-1:0] ssl_o,
    output logic [NUM_STR-1:0] gsl_o,
    output logic [NROW-1:0]   wl_sel_o,
    output logic [NROW-1:0]   wl_pass_o,
    output logic              wl_pgm_o,
    output logic              sl_o,
    output logic              vbpw_o,
    output logic [NUM_BL-1:0] bl_drive_o,
    output logic              bl_oe_o,
    output logic              sen1_o,
    output logic              sen2_o,
    output logic              out_en_o,
    input  logic [NUM_BL-1:0] sa_out_i
);

    localparam int CW = $clog2(T_SETUP + T_PRECH + T_SENSE + T_PGM + T_ERS + 1);
    localparam int PW = $clog2(MAX_PULSES + 1);
    localparam logic [NROW-1:0] STR_MASK = NROW'((64'd1 << WL_PER_STR) - 64'd1);
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_PGM = 2'b01;
    localparam logic [1:0] OP_ERS = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_PRECH, S_SENSE1, S_SENSE2,
        S_LATCH, S_PGM, S_PGM_REC, S_ERS, S_RESP
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic [ROW_W-1:0]  row_q;
    logic [NUM_BL-1:0] wdata_q, mask_q;
    logic [PW-1:0]     pulse_q;

    logic accept, illegal, done, pv_pass, last_pulse;
    logic [ROW_W-1:0] str_idx, str_base;

    assign cmd_ready  = (state == S_IDLE) && !wb_rst_i;
    assign accept     = cmd_valid && cmd_ready;
    assign illegal    = (cmd_op == 2'b11) || ((cmd_row >> WLB) >= ROW_W'(NUM_STR));
    assign done       = (cnt == '0);
    assign pv_pass    = (sa_out_i & ~wdata_q) == '0;
    assign last_pulse = (pulse_q + PW'(1)) == PW'(MAX_PULSES);
    assign str_idx    = row_q >> WLB;
    assign str_base   = row_q & ~ROW_W'(WL_PER_STR - 1);

    function automatic logic [CW-1:0] phase_len(input state_t s);
        unique case (s)
            S_SETUP:            phase_len = CW'(T_SETUP - 1);
            S_PRECH:            phase_len = CW'(T_PRECH - 1);
            S_SENSE1, S_SENSE2: phase_len = CW'(T_SENSE - 1);
            S_PGM:              phase_len = CW'(T_PGM - 1);
            S_ERS:              phase_len = CW'(T_ERS - 1);
            default:            phase_len = '0;
        endcase
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:    if (accept) state_d = illegal ? S_RESP : S_SETUP;
            S_SETUP:   if (done) state_d = (op_q == OP_PGM) ? S_PGM :
                                           (op_q == OP_ERS) ? S_ERS : S_PRECH;
            S_PRECH:   if (done) state_d = S_SENSE1;
            S_SENSE1:  if (done) state_d = S_SENSE2;
            S_SENSE2:  if (done) state_d = S_LATCH;
            S_LATCH:   state_d = (op_q != OP_PGM || pv_pass || last_pulse) ? S_RESP : S_PGM;
            S_PGM:     if (done) state_d = S_PGM_REC;
            S_PGM_REC: state_d = S_PRECH;
            S_ERS:     if (done) state_d = S_RESP;
            S_RESP:    if (rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt      <= '0;
            op_q     <= '0;
            row_q    <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            pulse_q  <= '0;
            rsp_data <= '0;
            rsp_fail <= 1'b0;
        end else begin
            if (state_d != state) cnt <= phase_len(state_d);
            else if (!done)       cnt <= cnt - CW'(1);
            if (accept) begin
                op_q     <= cmd_op;
                row_q    <= cmd_row;
                wdata_q  <= cmd_wdata;
                mask_q   <= cmd_wdata;
                pulse_q  <= '0;
                rsp_data <= '0;
                rsp_fail <= illegal;
            end
            if (state == S_LATCH) begin
                rsp_data <= sa_out_i;
                // Cells that already read programmed stay inhibited on later pulses
                if (op_q == OP_PGM) begin
                    mask_q <= mask_q | ~sa_out_i;
                    if (!pv_pass) begin
                        pulse_q <= pulse_q + PW'(1);
                        if (last_pulse) rsp_fail <= 1'b1;
                    end
                end
            end
        end
    end

    logic act, wl_on;

    always_comb begin
        act   = !(state == S_IDLE || state == S_RESP);
        wl_on = (state == S_SETUP && op_q != OP_ERS) ||
                (state inside {S_PRECH, S_SENSE1, S_SENSE2, S_LATCH, S_PGM});
        busy       = state != S_IDLE;
        rsp_valid  = state == S_RESP;
        ssl_o      = act ? (NUM_STR'(1) << str_idx) : '0;
        gsl_o      = ssl_o;
        wl_sel_o   = wl_on ? (NROW'(1) << row_q) : '0;
        wl_pass_o  = wl_on ? ((STR_MASK << str_base) & ~(NROW'(1) << row_q)) : '0;
        wl_pgm_o   = state == S_PGM;
        sl_o       = state == S_ERS;
        vbpw_o     = state == S_ERS;
        bl_oe_o    = (state == S_PRECH) || (state == S_PGM);
        bl_drive_o = '0;
        if (state == S_PRECH) bl_drive_o = '1;
        if (state == S_PGM)   bl_drive_o = mask_q;
        sen1_o     = state == S_SENSE1;
        sen2_o     = state == S_SENSE2;
        out_en_o   = state == S_LATCH;
    end

endmodule

// File: tb/tb_flash_array_ctrl.sv
// Scoreboard bench for flash_array_ctrl: directed commands, queued
// expected responses, and a monitor that compares on each handshake.
module tb_flash_array_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_row = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_data;
    logic        rsp_fail;
    logic        busy;
    logic [2:0]  ssl_o, gsl_o;
    logic [11:0] wl_sel_o, wl_pass_o;
    logic        wl_pgm_o, sl_o, vbpw_o, bl_oe_o, sen1_o, sen2_o, out_en_o;
    logic [7:0]  bl_drive_o;
    logic [7:0]  sa = 8'hFF;

    always #5 clk = ~clk;

    flash_array_ctrl #(.NUM_BL(8), .NUM_STR(3), .WL_PER_STR(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fail(rsp_fail), .busy(busy),
        .ssl_o(ssl_o), .gsl_o(gsl_o), .wl_sel_o(wl_sel_o), .wl_pass_o(wl_pass_o),
        .wl_pgm_o(wl_pgm_o), .sl_o(sl_o), .vbpw_o(vbpw_o),
        .bl_drive_o(bl_drive_o), .bl_oe_o(bl_oe_o),
        .sen1_o(sen1_o), .sen2_o(sen2_o), .out_en_o(out_en_o),
        .sa_out_i(sa)
    );

    wire [44:0] arr = {ssl_o, gsl_o, wl_sel_o, wl_pass_o, wl_pgm_o, sl_o, vbpw_o,
                       bl_drive_o, bl_oe_o, sen1_o, sen2_o, out_en_o};

    int tests = 0;
    int fails = 0;
    int inv_bad = 0;

    typedef struct packed { logic [7:0] d; logic f; } rsp_t;
    rsp_t exp_q[$];
    rsp_t e;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(ssl_o) || !$onehot0(gsl_o) || !$onehot0(wl_sel_o) ||
                (wl_pgm_o && vbpw_o) || (sen1_o && sen2_o))
                inv_bad++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.d);
                    check("rsp_fail", rsp_fail, e.f);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] row, input logic [7:0] wd);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("ready_timeout", 0, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check("rsp_timeout", 0, 1);
    endtask

    task automatic pgm_run(input logic [3:0] row, input logic [7:0] wd,
                           input logic [7:0] sa1, input logic [7:0] sa2,
                           output int pulses, output int hi,
                           output logic [7:0] d1, output logic [7:0] d2);
        logic prev;
        int n;
        prev = 1'b0; n = 0; pulses = 0; hi = 0; d1 = '0; d2 = '0;
        sa = 8'hFF;
        send(2'b01, row, wd);
        while (!rsp_valid && n < 1000) begin
            @(negedge clk); n++;
            if (wl_pgm_o) begin
                hi++;
                if (!prev) begin
                    pulses++;
                    if (pulses == 1) begin d1 = bl_drive_o; sa = sa1; end
                    else begin
                        if (pulses == 2) d2 = bl_drive_o;
                        sa = sa2;
                    end
                end
            end
            prev = wl_pgm_o;
        end
        if (n >= 1000) check("pgm_timeout", 0, 1);
    endtask

    initial begin
        int pulses, hi, n, wl_bad, ssl_bad, stable_bad;
        logic [7:0] d1, d2;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_array", arr, 0);

        // READ row 5 -> string 1, wl 1
        sa = 8'hA5;
        exp_q.push_back('{8'hA5, 1'b0});
        send(2'b00, 4'd5, 8'h00);
        @(negedge clk);
        check("rd_ssl", ssl_o, 3'b010);
        check("rd_gsl", gsl_o, 3'b010);
        check("rd_wl_sel", wl_sel_o, 12'h020);
        check("rd_wl_pass", wl_pass_o, 12'h0D0);
        check("rd_busy_ready", {busy, cmd_ready}, 2'b10);
        repeat (2) @(negedge clk);
        check("rd_prech", {bl_oe_o, bl_drive_o}, 9'h1FF);
        repeat (4) @(negedge clk);
        check("rd_sen1", {sen1_o, sen2_o, bl_oe_o}, 3'b100);
        repeat (6) @(negedge clk);
        check("rd_latch", {out_en_o, rsp_valid}, 2'b10);
        @(negedge clk);
        check("rd_rsp_13", rsp_valid, 1);
        wait_idle();

        // PROGRAM F0: partial after pulse 1, done after pulse 2
        exp_q.push_back('{8'hF0, 1'b0});
        pgm_run(4'd9, 8'hF0, 8'hF3, 8'hF0, pulses, hi, d1, d2);
        check("pgm2_pulses", pulses, 2);
        check("pgm2_hi", hi, 16);
        check("pgm2_drive1", d1, 8'hF0);
        check("pgm2_drive2", d2, 8'hFC);
        wait_idle();

        // PROGRAM 00 with a stuck cell -> fail after MAX_PULSES
        exp_q.push_back('{8'h01, 1'b1});
        pgm_run(4'd0, 8'h00, 8'h01, 8'h01, pulses, hi, d1, d2);
        check("pgmf_pulses", pulses, 4);
        check("pgmf_hi", hi, 32);
        check("pgmf_drive2", d2, 8'hFE);
        wait_idle();

        // PROGRAM all ones: one fully inhibited pulse
        exp_q.push_back('{8'hFF, 1'b0});
        pgm_run(4'd3, 8'hFF, 8'hFF, 8'hFF, pulses, hi, d1, d2);
        check("pgm1_pulses", pulses, 1);
        check("pgm1_drive", d1, 8'hFF);
        wait_idle();

        // Illegal string and reserved op
        exp_q.push_back('{8'h00, 1'b1});
        send(2'b00, 4'd13, 8'h00);
        @(negedge clk);
        check("ill_rsp_now", rsp_valid, 1);
        check("ill_array", arr, 0);
        wait_idle();
        exp_q.push_back('{8'h00, 1'b1});
        send(2'b11, 4'd0, 8'h00);
        @(negedge clk);
        check("op11_array", {rsp_valid, arr}, {1'b1, 45'd0});
        wait_idle();

        // ERASE row 2 with delayed response accept
        rsp_ready = 1'b0;
        exp_q.push_back('{8'h00, 1'b0});
        send(2'b10, 4'd2, 8'h00);
        n = 0; hi = 0; wl_bad = 0; ssl_bad = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk); n++;
            if (vbpw_o && sl_o) hi++;
            if (wl_sel_o != 0 || wl_pass_o != 0) wl_bad++;
            if (!rsp_valid && ssl_o != 3'b001) ssl_bad++;
        end
        check("ers_len", n, 19);
        check("ers_hi", hi, 16);
        check("ers_wl_off", wl_bad, 0);
        check("ers_ssl", ssl_bad, 0);
        stable_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_data != 0 || rsp_fail) stable_bad++;
        end
        check("ers_hold", stable_bad, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle();

        // Reset during a program pulse
        sa = 8'h01;
        send(2'b01, 4'd5, 8'h00);
        n = 0;
        while (!wl_pgm_o && n < 100) begin @(negedge clk); n++; end
        check("mid_pgm_seen", wl_pgm_o, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_drop", {wl_pgm_o, bl_oe_o, ssl_o, busy}, 6'd0);
        @(posedge clk); #1 rst = 1'b0;
        sa = 8'h3C;
        exp_q.push_back('{8'h3C, 1'b0});
        send(2'b00, 4'd5, 8'h00);
        wait_rsp();
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("invariants", inv_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
